uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART TX datapath between NUM_REQ byte requesters (e.g. RX loopback, register readback, status reporter). It selects a requester, latches its byte and frame configuration (parity enable and type), and issues it to the TX core as a one-cycle data-valid strobe. It then tracks the TX busy flag through the full frame and reports completion or a start timeout to the owning requester. It sits between the requester bank and the UART TX top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width per frame
BUSY_TIMEOUT, 16, CLK cycles allowed for TX_BUSY to rise after issue (>=2)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
REQ  in  NUM_REQ  per-requester request level; held until GNT seen
REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
REQ_PAR_EN  in  NUM_REQ  per-requester parity enable
REQ_PAR_TYP  in  NUM_REQ  per-requester parity type (0 even, 1 odd)
GNT  out  NUM_REQ  one-hot, one-cycle pulse: byte taken
DONE  out  NUM_REQ  one-hot, one-cycle pulse: frame fully shifted out
ERR_TIMEOUT  out  1  one-cycle pulse: TX never went busy
ACTIVE_ID  out  clog2(NUM_REQ)  index of current owner
SCHED_BUSY  out  1  high in every state except IDLE
TX_P_DATA  out  DATA_WIDTH  latched byte to TX
TX_PAR_EN  out  1  latched parity enable
TX_PAR_TYP  out  1  latched parity type
TX_DATA_VALID  out  1  one-cycle issue strobe
TX_BUSY  in  1  TX core busy flag

Behaviour:
- Reset (synchronous, RST=1 at CLK edge): state IDLE; all outputs 0; round-robin pointer 0 (requester 0 highest priority); timeout counter 0. Takes priority over every event, including mid-frame. No DONE or ERR_TIMEOUT is emitted for a frame aborted by reset.
- Gray-encoded states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if |REQ and TX_BUSY=0, arbitrate, then go to ISSUE. Otherwise stay in IDLE.
- Arbitration: the winner is the first set REQ bit scanning from pointer, pointer+1, ... with wrap modulo NUM_REQ. At that edge, latch REQ_DATA/PAR_EN/PAR_TYP of the winner into the TX_* registers. Set ACTIVE_ID = winner and pointer = winner+1 (wrap).
- ISSUE (exactly 1 cycle): TX_DATA_VALID=1 and GNT[ACTIVE_ID]=1. Clear the timeout counter. Next state is WAIT_BUSY.
- WAIT_BUSY:
  - TX_BUSY=1 -> WAIT_DONE.
  - Otherwise increment the counter (width clog2(BUSY_TIMEOUT+1), saturating). When the counter reaches BUSY_TIMEOUT-1 with TX_BUSY still 0, pulse ERR_TIMEOUT for one cycle and go to IDLE, with no DONE.
- WAIT_DONE: on TX_BUSY=0, pulse DONE[ACTIVE_ID] for one cycle and go to IDLE.
- GNT, DONE, ERR_TIMEOUT and TX_DATA_VALID are registered. Each is 1 for exactly one cycle and is never asserted together with another of its own kind.
- TX_* data/config registers hold their value from ISSUE until the next arbitration. They are unchanged during WAIT_BUSY and WAIT_DONE.
- Latency: REQ high in IDLE -> TX_DATA_VALID after 1 edge (visible in the next cycle). Throughput is one frame at a time; re-arbitration happens only in IDLE, at earliest 1 cycle after DONE.
- REQ deasserting after arbitration has no effect on the current frame. REQ changes outside IDLE are ignored.
- A requester that keeps REQ high after GNT gets a new frame only after every other pending requester has been served once.
- TX_BUSY=1 in IDLE blocks arbitration (foreign or leftover frame).
- ACTIVE_ID holds its last value in IDLE.

Decomposition:
- Package uart_tx_sched_pkg: state localparams (IDLE=2'b00, ISSUE=2'b01, WAIT_BUSY=2'b11, WAIT_DONE=2'b10) and a default BUSY_TIMEOUT constant.
- One sub-module rr_arbiter. Ports: req vector, pointer -> one-hot grant plus encoded index; purely combinational.
- FSM, pointer, counter and output registers live in uart_tx_sched.

Test Plan:
1. REQ=4'b0001, REQ_DATA[7:0]=8'hA5, PAR_EN=1, PAR_TYP=1; TX model raises busy 1 cycle after valid and holds it 11 cycles.
   -> TX_DATA_VALID pulse 1 cycle after REQ with TX_P_DATA=A5, TX_PAR_EN=1, TX_PAR_TYP=1; GNT=0001 in the same cycle; DONE=0001 one cycle after busy falls.
2. REQ=4'b1111 held continuously.
   -> grant order 0,1,2,3,0. ACTIVE_ID follows the same order. Exactly 5 DONE pulses, one per frame.
3. TX model never raises busy, BUSY_TIMEOUT=16.
   -> ERR_TIMEOUT pulse 16 cycles after ISSUE; no DONE; state returns to IDLE; the next request is still served.
4. RST=1 for 1 cycle during WAIT_DONE of requester 2.
   -> all outputs 0 next cycle. No DONE for requester 2. Pointer is 0, so with REQ=4'b0110 requester 1 wins.
5. TX_BUSY held 1 while REQ=4'b0010.
   -> no GNT or TX_DATA_VALID until TX_BUSY=0; then grant to 1 within 1 cycle.
6. REQ[3] dropped in the cycle after GNT[3] while REQ[0] is high.
   -> frame for 3 completes with DONE[3]; next grant goes to 0.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART TX request scheduler.
// Contents:
//   - Gray-coded FSM state constants. Adjacent transitions flip one bit.
//   - Default start-of-frame timeout, in clock cycles.
package uart_tx_sched_pkg;

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_ISSUE     = 2'b01;
  localparam logic [1:0] ST_WAIT_BUSY = 2'b11;
  localparam logic [1:0] ST_WAIT_DONE = 2'b10;

  localparam int DEFAULT_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i  - request vector, one bit per requester
//   ptr_i  - index of the highest-priority requester for this round
//   gnt_o  - one-hot grant, all zero when there is no request
//   idx_o  - encoded index of the granted requester
//   any_o  - at least one request is pending
module uart_tx_sched_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Requests at or above the pointer. If any exist, the lowest of them wins.
  // Otherwise the scan wraps, and the lowest request overall wins.
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign req_hi[gi] = req_i[gi] & (gi >= int'(ptr_i));
    end
  endgenerate

  always_comb begin
    sel   = (|req_hi) ? req_hi : req_i;
    gnt_o = '0;
    idx_o = '0;
    // Scan downward so the lowest selected index is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (sel[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART TX datapath among NUM_REQ requesters.
// Operation:
//   - Picks a requester and latches its byte and parity configuration.
//   - Issues the frame with a one-cycle TX_DATA_VALID strobe.
//   - Follows TX_BUSY through the frame.
//   - Reports DONE to the owner, or ERR_TIMEOUT if TX never went busy.
// Ports:
//   CLK, RST          - clock, synchronous active-high reset
//   REQ               - per-requester request level, held until GNT
//   REQ_DATA          - packed bytes; requester i uses [i*DATA_WIDTH +: DATA_WIDTH]
//   REQ_PAR_EN/TYP    - per-requester parity enable and type (1 = odd)
//   GNT, DONE         - one-hot single-cycle pulses to the owning requester
//   ERR_TIMEOUT       - single-cycle pulse; TX_BUSY never rose after issue
//   ACTIVE_ID         - index of the current or most recent owner
//   SCHED_BUSY        - high whenever the scheduler is not idle
//   TX_P_DATA/PAR_*   - latched frame contents for the TX core
//   TX_DATA_VALID     - single-cycle issue strobe
//   TX_BUSY           - TX core busy flag
import uart_tx_sched_pkg::*;

module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            DONE,
  output logic                          ERR_TIMEOUT,
  output logic [$clog2(NUM_REQ)-1:0]    ACTIVE_ID,
  output logic                          SCHED_BUSY,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_PAR_EN,
  output logic                          TX_PAR_TYP,
  output logic                          TX_DATA_VALID,
  input  logic                          TX_BUSY
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         active_id_q, active_id_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_par_en_q, tx_par_en_d;
  logic                  tx_par_typ_q, tx_par_typ_d;
  logic                  valid_q, valid_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  err_q, err_d;

  // Unpack the requester bytes so the winner's byte can be selected by index.
  logic [DATA_WIDTH-1:0] req_byte [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_byte[gi] = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  uart_tx_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_arb (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // A busy TX in IDLE is a foreign or leftover frame, so it blocks arbitration.
  logic arb_fire;
  assign arb_fire = (state_q == ST_IDLE) && arb_any && !TX_BUSY;

  // Saturating increment. The timeout fires on the edge where the count
  // becomes BUSY_TIMEOUT-1, so ERR_TIMEOUT appears BUSY_TIMEOUT cycles after
  // the issue strobe.
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  assign cnt_inc     = (cnt_q == CW'(BUSY_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = !TX_BUSY && (cnt_inc == CW'(BUSY_TIMEOUT - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (arb_fire) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (TX_BUSY)          state_d = ST_WAIT_DONE;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: if (!TX_BUSY) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-values. Pulses are computed one edge early and
  // registered, so each one is visible in the cycle of the matching state.
  always_comb begin
    ptr_d        = ptr_q;
    active_id_d  = active_id_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    tx_par_en_d  = tx_par_en_q;
    tx_par_typ_d = tx_par_typ_q;
    valid_d      = 1'b0;
    gnt_d        = '0;
    done_d       = '0;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_fire) begin
          tx_data_d    = req_byte[arb_idx];
          tx_par_en_d  = REQ_PAR_EN[arb_idx];
          tx_par_typ_d = REQ_PAR_TYP[arb_idx];
          active_id_d  = arb_idx;
          ptr_d        = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          valid_d      = 1'b1;
          gnt_d        = arb_gnt;
        end
      end
      ST_ISSUE: cnt_d = '0;
      ST_WAIT_BUSY: begin
        if (!TX_BUSY) begin
          cnt_d = cnt_inc;
          err_d = timeout_hit;
        end
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) done_d[active_id_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q        <= '0;
      active_id_q  <= '0;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      tx_par_en_q  <= 1'b0;
      tx_par_typ_q <= 1'b0;
      valid_q      <= 1'b0;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      active_id_q  <= active_id_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_par_typ_q <= tx_par_typ_d;
      valid_q      <= valid_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign GNT           = gnt_q;
  assign DONE          = done_q;
  assign ERR_TIMEOUT   = err_q;
  assign ACTIVE_ID     = active_id_q;
  assign SCHED_BUSY    = (state_q != ST_IDLE);
  assign TX_P_DATA     = tx_data_q;
  assign TX_PAR_EN     = tx_par_en_q;
  assign TX_PAR_TYP    = tx_par_typ_q;
  assign TX_DATA_VALID = valid_q;

endmodule
